fir_result_tx: RTL

SPI-responder transmit path for the FIR filter. It captures each finished filter result, when the controller strobes it, into a holding register. On every SPI frame from the external master it shifts out a 24-bit word, MSB first: an 8-bit status byte followed by the 16-bit result. It sits beside the SPI receive path and the FIR controller, and shares the nss/sclk pads with the receive side.

---
 rtl/fir_spi_pkg.sv | 15 +
 rtl/sync_edge.sv | 32 +++
 rtl/fir_result_tx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fir_spi_pkg.sv
// rtl/fir_spi_pkg.sv - shared types and constants for the FIR SPI responder
package fir_spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    COMPLETE = 2'd2
  } tx_state_t;

  localparam int FRAME_BITS = 24;
  localparam int STAT_FRESH = 7;
  localparam int STAT_ERR   = 6;
  localparam int STAT_OVR   = 5;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with registered rise/fall pulses
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      prev <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
      rise <= sync & ~prev;
      fall <= ~sync & prev;
    end
  end

endmodule

// File: rtl/fir_result_tx.sv
// rtl/fir_result_tx.sv - SPI responder transmit path for FIR results
module fir_result_tx
  import fir_spi_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              sclk_in,
  input  logic              nss_in,
  input  logic [DATA_W-1:0] result,
  input  logic              result_strobe,
  input  logic              err_in,
  output logic              miso,
  output logic              miso_oe,
  output logic              tx_active,
  output logic              frame_done
);

  localparam int FRAME_W = DATA_W + 8;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  logic              sclk_fall;
  logic              unused_sclk_rise;
  logic              nss_rise;
  logic              nss_fall;
  tx_state_t         state_q;
  tx_state_t         state_d;
  logic              load;
  logic              shift;
  logic              clear;
  logic [DATA_W-1:0] hold_data;
  logic              fresh;
  logic              err_l;
  logic              ovr;
  logic [4:0]        seq;
  logic [7:0]        status;
  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]  bitcnt;

  sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .n_rst(n_rst),
    .din  (sclk_in),
    .rise (unused_sclk_rise),
    .fall (sclk_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_nss_sync (
    .clk  (clk),
    .n_rst(n_rst),
    .din  (nss_in),
    .rise (nss_rise),
    .fall (nss_fall)
  );

  always_comb begin
    status             = {3'b000, seq};
    status[STAT_FRESH] = fresh;
    status[STAT_ERR]   = err_l;
    status[STAT_OVR]   = ovr;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    shift      = 1'b0;
    clear      = 1'b0;
    miso       = 1'b0;
    miso_oe    = 1'b0;
    tx_active  = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (nss_fall) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        miso      = shreg[FRAME_W-1];
        miso_oe   = 1'b1;
        tx_active = 1'b1;
        if (nss_rise) begin
          clear   = 1'b1;
          state_d = IDLE;
        end else if (sclk_fall) begin
          shift = 1'b1;
          if (bitcnt == CNT_W'(FRAME_W - 1)) state_d = COMPLETE;
        end
      end
      COMPLETE: begin
        miso_oe   = 1'b1;
        tx_active = 1'b1;
        if (nss_rise) begin
          clear      = 1'b1;
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (clear) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (load) begin
      shreg  <= {status, hold_data};
      bitcnt <= '0;
    end else if (shift) begin
      shreg  <= {shreg[FRAME_W-2:0], 1'b0};
      bitcnt <= bitcnt + 1'b1;
    end
  end

  // A strobe coinciding with a frame load re-arms fresh but is not an overrun:
  // the previous result has just been taken by the frame.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_data <= '0;
      err_l     <= 1'b0;
      fresh     <= 1'b0;
      ovr       <= 1'b0;
      seq       <= '0;
    end else if (result_strobe) begin
      hold_data <= result;
      err_l     <= err_in;
      fresh     <= 1'b1;
      ovr       <= load ? 1'b0 : (ovr | fresh);
      seq       <= seq + 5'd1;
    end else if (load) begin
      fresh <= 1'b0;
      ovr   <= 1'b0;
    end
  end

endmodule
